// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and output register for an N:1 word mux.
// N requesters compete for one WIDTH-bit output channel using valid/ready
// handshakes. The mux select is generated internally and registered along with
// the selected word. Optional feature macro: MUX_ARB_LOCK_EN. When it is defined,
// a req_lock_i port lets the granted requester keep the channel for a burst.

package mux_pkg;
  localparam int N     = 4;
  localparam int WIDTH = 8;
endpackage

module mux_rr_arbiter #(
  parameter int N     = mux_pkg::N,
  parameter int WIDTH = mux_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid_i,
  input  logic [WIDTH-1:0]     req_data_i [N],
  output logic [N-1:0]         req_ready_o,
  output logic                 out_valid_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [$clog2(N)-1:0] out_sel_o,
  input  logic                 out_ready_i
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [N-1:0]         req_lock_i
`endif
);

  localparam int PW = $clog2(N);

  // The output stage is EMPTY or FULL. It is kept as an explicit state so the
  // drain and refill rules read as transitions.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  out_state_t       state_reg, state_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [PW-1:0]    out_sel_reg, out_sel_next;
  logic [PW-1:0]    ptr_reg, ptr_next;

  logic [N-1:0]     cand_valid;
  logic [PW-1:0]    scan_idx [N];
  logic [N-1:0]     scan_hit;
  logic             grant_found;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    grant_inc;
  logic             load_en;
  logic             accept;

`ifdef MUX_ARB_LOCK_EN
  logic             locked_reg, locked_next;
  logic [PW-1:0]    lock_idx_reg, lock_idx_next;
  logic [N-1:0]     lock_mask;
`endif

  // The register can take a new word when it is empty, or when it is being
  // drained in this same cycle. The second case is the no-bubble refill.
  assign load_en = (state_reg == ST_EMPTY) || out_ready_i;

  // Select the requesters that may compete this cycle. While locked, only the
  // lock owner is a candidate, even if it is currently idle.
`ifdef MUX_ARB_LOCK_EN
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lock_mask
      assign lock_mask[gi] = (lock_idx_reg == PW'(gi));
    end
  endgenerate

  assign cand_valid = locked_reg ? (req_valid_i & lock_mask) : req_valid_i;
`else
  genvar gi;
  assign cand_valid = req_valid_i;
`endif

  // Rotated scan order. Slot k examines requester (ptr + k) mod N. The sum is
  // one bit wider than the pointer, so the wrap test is exact for any N.
  generate
    for (gi = 0; gi < N; gi++) begin : g_scan
      logic [PW:0] sum;
      assign sum           = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign scan_idx[gi]  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                 : sum[PW-1:0];
      assign scan_hit[gi]  = cand_valid[scan_idx[gi]];
    end
  endgenerate

  // Pick the earliest hit in scan order. The loop walks backwards, so the
  // lowest slot is assigned last and therefore wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (scan_hit[k]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
  end

  // Pointer value after a grant, with an explicit wrap for non-power-of-2 N.
  assign grant_inc = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

  assign accept = load_en && grant_found;

  // Ready is one-hot on the granted requester, and only when a word can load.
  // It never depends on the data inputs.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Next-state logic for the output stage and the priority pointer.
  always_comb begin
    state_next    = state_reg;
    out_data_next = out_data_reg;
    out_sel_next  = out_sel_reg;
    ptr_next      = ptr_reg;

    if (accept) begin
      state_next    = ST_FULL;
      out_data_next = req_data_i[grant_idx];
      out_sel_next  = grant_idx;
`ifdef MUX_ARB_LOCK_EN
      // A burst beat with lock set keeps the pointer parked. The closing beat
      // moves the pointer past the owner.
      if (!req_lock_i[grant_idx]) begin
        ptr_next = grant_inc;
      end
`else
      ptr_next = grant_inc;
`endif
    end else if ((state_reg == ST_FULL) && out_ready_i) begin
      // Drained with nothing to replace it. Data and select keep their values.
      state_next = ST_EMPTY;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Lock tracking. The lock bit of each accepted beat decides whether its
  // requester keeps exclusive access for the next beat.
  always_comb begin
    locked_next   = locked_reg;
    lock_idx_next = lock_idx_reg;
    if (accept) begin
      if (req_lock_i[grant_idx]) begin
        locked_next   = 1'b1;
        lock_idx_next = grant_idx;
      end else begin
        locked_next   = 1'b0;
      end
    end
  end

  // Lock state register. Reset always releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_reg   <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      locked_reg   <= locked_next;
      lock_idx_reg <= lock_idx_next;
    end
  end
`endif

  // Output register and pointer. Reset discards any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      out_data_reg <= '0;
      out_sel_reg  <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      out_sel_reg  <= out_sel_next;
      ptr_reg      <= ptr_next;
    end
  end

  assign out_valid_o = (state_reg == ST_FULL);
  assign out_data_o  = out_data_reg;
  assign out_sel_o   = out_sel_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus randomized traffic for
// mux_rr_arbiter. Checks run against a cycle-level reference model that scans
// the requesters in modulo-N order. Define MUX_ARB_LOCK_EN to exercise locking.
module tb_mux_rr_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 8;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [WIDTH-1:0] req_data [N];
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_lock = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state.
  int           m_ptr;
  bit           m_full;
  logic [7:0]   m_data;
  int           m_sel;
  bit           m_locked;
  int           m_lock_idx;
  logic [N-1:0] last_ready = '0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .out_ready_i (out_ready)
`ifdef MUX_ARB_LOCK_EN
    ,
    .req_lock_i  (req_lock)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_sel = 0; m_locked = 0; m_lock_idx = 0;
  endfunction

  // Which requester may hand over a word this cycle, according to the rules:
  // no room means nobody; a lock means only the owner; otherwise the first
  // valid requester from ptr onwards, wrapping modulo N.
  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic ordy);
    logic [N-1:0] r;
    r = '0;
    if (m_full && !ordy) return r;
    if (m_locked) begin
      if (v[m_lock_idx]) r[m_lock_idx] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock cycle: drive the inputs, check ready before the edge, advance
  // the model, then check the registered outputs after the edge.
  task automatic drive_cycle(input logic [N-1:0] v, input logic ordy, input logic [N-1:0] lk);
    logic [N-1:0] er;
    int g;
    @(negedge clk);
    req_valid = v;
    out_ready = ordy;
    req_lock  = lk;
    #1;
    er = model_ready(v, ordy);
    last_ready = er;
    check("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    cyc++;
    if (er != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (er[i]) g = i;
      m_full = 1;
      m_data = req_data[g];
      m_sel  = g;
      if (LOCK_EN && lk[g]) begin
        m_locked = 1; m_lock_idx = g;
      end else begin
        m_locked = 0; m_ptr = (g + 1) % N;
      end
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_sel", 32'(out_sel), 32'(m_sel));
    $display("cyc %0d valid=%b ordy=%b lock=%b ready=%b -> out_valid=%0b sel=%0d data=%02h",
             cyc, v, ordy, lk, er, out_valid, out_sel, out_data);
  endtask

  initial begin
    int exp_seq2 [5];
    int exp_seq3 [4];
    logic [N-1:0] v;
    logic [N-1:0] lk;
    logic ordy;
    exp_seq2 = '{0, 1, 2, 3, 0};
    exp_seq3 = '{3, 1, 3, 1};
    for (int i = 0; i < N; i++) req_data[i] = '0;
    model_reset();

    // Reset state, including ready while held in reset (EMPTY, lowest valid).
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_ready_idle", 32'(req_ready), 32'd0);
    req_valid = 4'b0110;
    #1;
    check("rst_ready_lowest", 32'(req_ready), 32'b0010);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: nothing moves.
    repeat (3) drive_cycle(4'b0000, 1'b1, 4'b0000);

    // All four valid, full throughput, starting from ptr=0.
    req_data[0] = 8'h10; req_data[1] = 8'h21; req_data[2] = 8'h32; req_data[3] = 8'h43;
    for (int s = 0; s < 5; s++) begin
      drive_cycle(4'b1111, 1'b1, 4'b0000);
      check("rr_seq_sel", 32'(out_sel), 32'(exp_seq2[s]));
      check("rr_seq_data", 32'(out_data), 32'h10 + 32'h11 * 32'(exp_seq2[s]));
    end

    // Move ptr to 2 via requester 1, then only 1 and 3 compete.
    drive_cycle(4'b0010, 1'b1, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      drive_cycle(4'b1010, 1'b1, 4'b0000);
      check("skip_seq_sel", 32'(out_sel), 32'(exp_seq3[s]));
    end

    // Back-pressure: hold 0xA5 for 5 cycles, then refill without a bubble.
    req_data[0] = 8'hA5;
    drive_cycle(4'b0001, 1'b1, 4'b0000);
    for (int s = 0; s < 5; s++) begin
      drive_cycle(4'b1111, 1'b0, 4'b0000);
      check("hold_data", 32'(out_data), 32'hA5);
      check("hold_sel", 32'(out_sel), 32'd0);
    end
    drive_cycle(4'b1111, 1'b1, 4'b0000);
    check("refill_valid", 32'(out_valid), 32'd1);
    check("refill_sel", 32'(out_sel), 32'd1);
    check("refill_data", 32'(out_data), 32'h21);

    // Asynchronous reset in the middle of a cycle while FULL.
    drive_cycle(4'b1000, 1'b0, 4'b0000);
    check("pre_rst_full", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(4'b1010, 1'b1, 4'b0000);
    check("post_rst_sel", 32'(out_sel), 32'd1);

`ifdef MUX_ARB_LOCK_EN
    // Lock burst from requester 2 (ptr is now 2), with a stall mid-burst.
    req_data[0] = 8'h01; req_data[1] = 8'h02; req_data[2] = 8'h03; req_data[3] = 8'h04;
    drive_cycle(4'b1111, 1'b1, 4'b0100);
    check("lock_b0_sel", 32'(out_sel), 32'd2);
    drive_cycle(4'b1011, 1'b1, 4'b0100);
    check("lock_stall_valid", 32'(out_valid), 32'd0);
    drive_cycle(4'b1111, 1'b1, 4'b0100);
    check("lock_b1_sel", 32'(out_sel), 32'd2);
    drive_cycle(4'b1111, 1'b1, 4'b0000);
    check("lock_b2_sel", 32'(out_sel), 32'd2);
    drive_cycle(4'b1111, 1'b1, 4'b0000);
    check("lock_after_sel", 32'(out_sel), 32'd3);
`endif

    // Randomized traffic. A requester keeps its valid and data until accepted.
    v = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !last_ready[i])) begin
          v[i] = 1'($urandom_range(0, 1));
          req_data[i] = 8'($urandom);
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      lk = '0;
`ifdef MUX_ARB_LOCK_EN
      for (int i = 0; i < N; i++) lk[i] = ($urandom_range(0, 3) == 0);
`endif
      drive_cycle(v, ordy, lk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the parametric N:1 mux datapath. It shares one WIDTH-bit output channel between N requesters using per-requester valid/ready handshakes. It generates the mux select internally and registers the selected word with its source index. It sits upstream of consumers that previously drove `sel_i` by hand, and replaces the static select with fair, back-pressure-aware scheduling.

## Interface
- `N`, default `mux_pkg::N` (4): number of requesters, ≥2.
- `WIDTH`, default `mux_pkg::WIDTH` (8): data width per requester.
- `clk` input, 1 bit: single clock; all state on rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `req_valid_i` input, [N]: requester i offers a word.
- `req_data_i` input, [WIDTH-1:0] x [N]: requester words, unpacked array like `mux_i`.
- `req_ready_o` output, [N]: one-hot or zero; word i accepted this cycle.
- `out_valid_o` output, 1 bit: output register holds a word.
- `out_data_o` output, [WIDTH-1:0]: registered selected word.
- `out_sel_o` output, [$clog2(N)-1:0]: index of the requester that supplied `out_data_o`.
- `out_ready_i` input, 1 bit: consumer accepts the output word.
- `req_lock_i` input, [N]: only present with `MUX_ARB_LOCK_EN`; see Configuration.

## Operation
- Output stage has two states: EMPTY (`out_valid_o`=0) and FULL (`out_valid_o`=1).
- `load_en` = !out_valid_o || out_ready_i. This gives a pass-through refill when FULL and drained in the same cycle.
- Priority pointer `ptr` has width $clog2(N) and resets to 0.
- Grant `g` is the first i with `req_valid_i[i]`=1, scanning ptr, ptr+1, … with modulo-N wrap.
- `req_ready_o[g]` = load_en && any valid. All other ready bits are 0.
- `req_ready_o` is combinational from `req_valid_i`, `out_valid_o`, `out_ready_i` and `ptr`. It does not depend on `req_data_i`.
- On accept (valid && ready for g):
  - `out_data_o` <= req_data_i[g]
  - `out_sel_o` <= g
  - `out_valid_o` <= 1
  - `ptr` <= (g+1) mod N. Wrap is explicit for non-power-of-2 N: g=N-1 gives ptr=0.
- On out_ready_i && out_valid_o with no accept: `out_valid_o` <= 0. Data and select hold their last values.
- When no requester is valid, state is unchanged apart from the drain above. `ptr` does not move.
- Requesters must hold `req_valid_i` and data stable until accepted. The arbiter does not check this.
- Fairness: a continuously valid requester waits at most N-1 accepts before it is granted.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_data_o`='0, `out_sel_o`=0
  - `ptr`=0; lock state cleared
  - `req_ready_o`=1 for the lowest valid index (EMPTY state), otherwise 0
- Latency: a word accepted in cycle t appears on `out_data_o`/`out_valid_o` in cycle t+1.
- Throughput: one word per cycle while `out_ready_i`=1.
- Back-pressure: while FULL and `out_ready_i`=0, all `req_ready_o`=0 and the output is held stable.
- Reset asserted mid-transfer: the output word is discarded immediately (asynchronous) and `ptr` returns to 0.
- Simultaneous drain and accept in one cycle: the new word replaces the old one, `out_valid_o` stays 1, and there is no bubble.

## Configuration
- Macro: `MUX_ARB_LOCK_EN`.
- Defined:
  - The `req_lock_i` port exists.
  - If the word accepted from g had `req_lock_i[g]`=1, the arbiter enters LOCKED(g).
  - While LOCKED(g), only g can be granted; others get ready=0 even when g is not valid. `ptr` is not updated.
  - LOCKED is left on the accept of a beat from g with `req_lock_i[g]`=0. That beat sets `ptr`=(g+1) mod N.
  - Reset clears LOCKED.
- Undefined:
  - No `req_lock_i` port and no lock state.
  - Pure round-robin as described in Operation.

## Test plan
Parameters for all scenarios: N=4, WIDTH=8.
- Reset then idle: all valids 0 → `out_valid_o`=0, `out_data_o`=0, `out_sel_o`=0, `req_ready_o`=0; `ptr` stays 0.
- All four valid with data 0x10/0x21/0x32/0x43 and `out_ready_i`=1 → outputs appear in order sel 0,1,2,3,0 on consecutive cycles, each one cycle after its accept, with data matching.
- Only requesters 1 and 3 valid, starting from `ptr`=2 → sequence 3,1,3,1. Confirms wrap from 3 to 0 with skipping of invalid requesters.
- FULL with data 0xA5 and `out_ready_i`=0 for 5 cycles → data and select held, all ready=0. On release, a new word loads the same cycle with no bubble.
- `rst_n` pulsed low mid-cycle while FULL → `out_valid_o` drops at once without waiting for `clk`, and the next grant after release is the lowest valid index.
- With `MUX_ARB_LOCK_EN`: requester 2 sends 3 beats with lock=1,1,0 while 0/1/3 are valid → sel 2,2,2 then 3. Requester 2 going invalid mid-lock stalls all others.
